// File: rtl/l2_load_dir.sv
// l2_load_dir: direct-mapped L2 directory engine for load requests (type 0x1f).
// A request on msg1 is looked up against per-set tag/valid-dirty/coherence state.
// The engine then answers with a data ack on msg2, or it issues coherence/memory
// requests on msg2 and collects the responses on msg3, replaying the request
// until it can complete.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   msg1_valid/ready         load request handshake (ready only in IDLE)
//   msg1_type/source/addr    request type, requesting core, {tag, index} address
//   msg2_valid/ready         outgoing message handshake (registered, held under backpressure)
//   msg2_type/dest/addr/data outgoing message fields
//   msg3_valid/ready         response handshake (ready only in WAIT)
//   msg3_type/data           response type and line data
//   busy                     engine not idle
//   replay_cnt               saturating count of replays since reset
module l2_load_dir #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned TAG_W     = 26,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_CORES = 64,
    localparam int unsigned SRC_W    = $clog2(NUM_CORES),
    localparam int unsigned ADDR_W   = TAG_W + IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg1_valid,
    output logic              msg1_ready,
    input  logic [7:0]        msg1_type,
    input  logic [SRC_W-1:0]  msg1_source,
    input  logic [ADDR_W-1:0] msg1_addr,
    output logic              msg2_valid,
    input  logic              msg2_ready,
    output logic [7:0]        msg2_type,
    output logic [SRC_W-1:0]  msg2_dest,
    output logic [ADDR_W-1:0] msg2_addr,
    output logic [DATA_W-1:0] msg2_data,
    input  logic              msg3_valid,
    output logic              msg3_ready,
    input  logic [7:0]        msg3_type,
    input  logic [DATA_W-1:0] msg3_data,
    output logic              busy,
    output logic [7:0]        replay_cnt
);

    localparam int unsigned NUM_SETS = 2 ** IDX_W;

    localparam logic [7:0] MsgLoadReq   = 8'h1f;
    localparam logic [7:0] MsgDataAck   = 8'h1d;
    localparam logic [7:0] MsgFwdDown   = 8'h10;
    localparam logic [7:0] MsgEvictOwn  = 8'h11;
    localparam logic [7:0] MsgEvictShr  = 8'h12;
    localparam logic [7:0] MsgMemRead   = 8'h13;
    localparam logic [7:0] MsgWriteback = 8'h14;
    localparam logic [7:0] RspMemData   = 8'h20;
    localparam logic [7:0] RspFwdAck    = 8'h21;
    localparam logic [7:0] RspInvAck    = 8'h22;

    localparam logic [1:0] VdInvalid = 2'd0;
    localparam logic [1:0] VdClean   = 2'd2;
    localparam logic [1:0] VdDirty   = 2'd3;
    localparam logic [1:0] LineI     = 2'd0;
    localparam logic [1:0] LineS     = 2'd1;
    localparam logic [1:0] LineM     = 2'd2;

    localparam logic [NUM_CORES-1:0] OneCore = NUM_CORES'(1);

    typedef enum logic [2:0] {StIdle, StLookup, StSend, StWait, StReplay} fsm_e;

    // Per-set directory storage
    logic [TAG_W-1:0]     tag_q    [NUM_SETS];
    logic [1:0]           vd_q     [NUM_SETS];
    logic [1:0]           lstate_q [NUM_SETS];
    logic [SRC_W-1:0]     owner_q  [NUM_SETS];
    logic [NUM_CORES-1:0] share_q  [NUM_SETS];
    logic [DATA_W-1:0]    data_q   [NUM_SETS];

    fsm_e               fsm_q, fsm_d, after_q;
    logic               ready_en_q;
    logic [SRC_W-1:0]   req_src_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [7:0]         pend_type_q;
    logic               msg2_valid_q;
    logic [7:0]         msg2_type_q;
    logic [SRC_W-1:0]   msg2_dest_q;
    logic [ADDR_W-1:0]  msg2_addr_q;
    logic [DATA_W-1:0]  msg2_data_q;
    logic [7:0]         replay_cnt_q;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [TAG_W-1:0]     cur_tag;
    logic [1:0]           cur_vd, cur_state;
    logic [SRC_W-1:0]     cur_owner;
    logic [NUM_CORES-1:0] cur_share;
    logic [DATA_W-1:0]    cur_data;
    logic                 hit;

    logic                 accept, msg_load, set_we;
    fsm_e                 lk_after;
    logic [7:0]           lk_type;
    logic [SRC_W-1:0]     lk_dest;
    logic [ADDR_W-1:0]    lk_addr;
    logic [DATA_W-1:0]    lk_data;
    logic [TAG_W-1:0]     set_tag_d;
    logic [1:0]           set_vd_d, set_state_d;
    logic [SRC_W-1:0]     set_owner_d;
    logic [NUM_CORES-1:0] set_share_d;
    logic [DATA_W-1:0]    set_data_d;

    assign req_idx   = req_addr_q[IDX_W-1:0];
    assign req_tag   = req_addr_q[ADDR_W-1:IDX_W];
    assign cur_tag   = tag_q[req_idx];
    assign cur_vd    = vd_q[req_idx];
    assign cur_state = lstate_q[req_idx];
    assign cur_owner = owner_q[req_idx];
    assign cur_share = share_q[req_idx];
    assign cur_data  = data_q[req_idx];
    assign hit       = (cur_tag == req_tag) && cur_vd[1];

    // ready_en_q keeps msg1_ready low during reset and until the first clock after it
    assign msg1_ready = (fsm_q == StIdle) && ready_en_q;
    assign msg3_ready = (fsm_q == StWait);
    assign busy       = (fsm_q != StIdle);
    assign msg2_valid = msg2_valid_q;
    assign msg2_type  = msg2_type_q;
    assign msg2_dest  = msg2_dest_q;
    assign msg2_addr  = msg2_addr_q;
    assign msg2_data  = msg2_data_q;
    assign replay_cnt = replay_cnt_q;

    always_comb begin
        fsm_d       = fsm_q;
        accept      = 1'b0;
        msg_load    = 1'b0;
        lk_after    = StIdle;
        lk_type     = '0;
        lk_dest     = '0;
        lk_addr     = '0;
        lk_data     = '0;
        set_we      = 1'b0;
        set_tag_d   = cur_tag;
        set_vd_d    = cur_vd;
        set_state_d = cur_state;
        set_owner_d = cur_owner;
        set_share_d = cur_share;
        set_data_d  = cur_data;

        case (fsm_q)
            StIdle: begin
                // Non-load types are consumed by the handshake and dropped
                if (msg1_valid && msg1_ready && (msg1_type == MsgLoadReq)) begin
                    accept = 1'b1;
                    fsm_d  = StLookup;
                end
            end
            StLookup: begin
                fsm_d    = StSend;
                msg_load = 1'b1;
                lk_addr  = req_addr_q;
                lk_after = StWait;
                if (hit) begin
                    lk_type  = MsgDataAck;
                    lk_dest  = req_src_q;
                    lk_data  = cur_data;
                    lk_after = StIdle;
                    if (cur_state == LineI) begin
                        set_we      = 1'b1;
                        set_state_d = LineM;
                        set_owner_d = req_src_q;
                    end else if (cur_state == LineS) begin
                        set_we      = 1'b1;
                        set_share_d = cur_share | (OneCore << req_src_q);
                    end else if (cur_owner != req_src_q) begin
                        lk_type  = MsgFwdDown;
                        lk_dest  = cur_owner;
                        lk_data  = '0;
                        lk_after = StWait;
                    end
                end else if (cur_vd == VdInvalid) begin
                    lk_type = MsgMemRead;
                end else if (cur_state == LineM) begin
                    lk_type = MsgEvictOwn;
                    lk_dest = cur_owner;
                    lk_addr = {cur_tag, req_idx};
                end else if (cur_state == LineS) begin
                    lk_type = MsgEvictShr;
                    lk_addr = {cur_tag, req_idx};
                end else if (cur_vd == VdDirty) begin
                    lk_type  = MsgWriteback;
                    lk_addr  = {cur_tag, req_idx};
                    lk_data  = cur_data;
                    lk_after = StReplay;
                    set_we   = 1'b1;
                    set_vd_d = VdInvalid;
                end else begin
                    // Clean victim in I: drop it silently and retry
                    msg_load = 1'b0;
                    fsm_d    = StReplay;
                    set_we   = 1'b1;
                    set_vd_d = VdInvalid;
                end
            end
            StSend: begin
                if (msg2_ready) begin
                    fsm_d = after_q;
                end
            end
            StWait: begin
                if (msg3_valid) begin
                    case (msg3_type)
                        RspMemData: begin
                            fsm_d       = StReplay;
                            set_we      = 1'b1;
                            set_tag_d   = req_tag;
                            set_data_d  = msg3_data;
                            set_vd_d    = VdClean;
                            set_state_d = LineI;
                            set_share_d = '0;
                        end
                        RspFwdAck: begin
                            fsm_d       = StReplay;
                            set_we      = 1'b1;
                            set_state_d = LineS;
                            set_share_d = OneCore << cur_owner;
                            set_data_d  = msg3_data;
                            set_vd_d    = VdDirty;
                        end
                        RspInvAck: begin
                            fsm_d       = StReplay;
                            set_we      = 1'b1;
                            set_state_d = LineI;
                            set_share_d = '0;
                            // An evicted owner returns the only up-to-date copy
                            if (pend_type_q == MsgEvictOwn) begin
                                set_data_d = msg3_data;
                                set_vd_d   = VdDirty;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StReplay: begin
                fsm_d = StLookup;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= StIdle;
            after_q      <= StIdle;
            ready_en_q   <= 1'b0;
            req_src_q    <= '0;
            req_addr_q   <= '0;
            pend_type_q  <= '0;
            msg2_valid_q <= 1'b0;
            msg2_type_q  <= '0;
            msg2_dest_q  <= '0;
            msg2_addr_q  <= '0;
            msg2_data_q  <= '0;
            replay_cnt_q <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_q[i]    <= '0;
                vd_q[i]     <= VdInvalid;
                lstate_q[i] <= LineI;
                owner_q[i]  <= '0;
                share_q[i]  <= '0;
                data_q[i]   <= '0;
            end
        end else begin
            fsm_q      <= fsm_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                req_src_q  <= msg1_source;
                req_addr_q <= msg1_addr;
            end
            if (msg_load) begin
                msg2_valid_q <= 1'b1;
                msg2_type_q  <= lk_type;
                msg2_dest_q  <= lk_dest;
                msg2_addr_q  <= lk_addr;
                msg2_data_q  <= lk_data;
                pend_type_q  <= lk_type;
                after_q      <= lk_after;
            end else if ((fsm_q == StSend) && msg2_ready) begin
                msg2_valid_q <= 1'b0;
            end
            if ((fsm_q == StReplay) && (replay_cnt_q != 8'hff)) begin
                replay_cnt_q <= replay_cnt_q + 8'd1;
            end
            if (set_we) begin
                tag_q[req_idx]    <= set_tag_d;
                vd_q[req_idx]     <= set_vd_d;
                lstate_q[req_idx] <= set_state_d;
                owner_q[req_idx]  <= set_owner_d;
                share_q[req_idx]  <= set_share_d;
                data_q[req_idx]   <= set_data_d;
            end
        end
    end

endmodule

// File: tb/tb_l2_load_dir.sv
// Self-checking bench for l2_load_dir: expected msg2 messages are queued as
// stimulus is driven and compared by a monitor as each msg2 handshake occurs.
module tb_l2_load_dir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        msg1_valid = 1'b0;
    logic        msg1_ready;
    logic [7:0]  msg1_type = '0;
    logic [5:0]  msg1_source = '0;
    logic [29:0] msg1_addr = '0;
    logic        msg2_valid;
    logic        msg2_ready = 1'b1;
    logic [7:0]  msg2_type;
    logic [5:0]  msg2_dest;
    logic [29:0] msg2_addr;
    logic [63:0] msg2_data;
    logic        msg3_valid = 1'b0;
    logic        msg3_ready;
    logic [7:0]  msg3_type = '0;
    logic [63:0] msg3_data = '0;
    logic        busy;
    logic [7:0]  replay_cnt;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  mtype;
        logic [5:0]  dest;
        logic [29:0] addr;
        logic [63:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];

    l2_load_dir dut (
        .clk         (clk),
        .rst         (rst),
        .msg1_valid  (msg1_valid),
        .msg1_ready  (msg1_ready),
        .msg1_type   (msg1_type),
        .msg1_source (msg1_source),
        .msg1_addr   (msg1_addr),
        .msg2_valid  (msg2_valid),
        .msg2_ready  (msg2_ready),
        .msg2_type   (msg2_type),
        .msg2_dest   (msg2_dest),
        .msg2_addr   (msg2_addr),
        .msg2_data   (msg2_data),
        .msg3_valid  (msg3_valid),
        .msg3_ready  (msg3_ready),
        .msg3_type   (msg3_type),
        .msg3_data   (msg3_data),
        .busy        (busy),
        .replay_cnt  (replay_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one pop per msg2 handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst && msg2_valid && msg2_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL msg2_unexpected: got type=%h dest=%0d addr=%h, required no message",
                         msg2_type, msg2_dest, msg2_addr);
            end else begin
                e = exp_q.pop_front();
                if (msg2_type !== e.mtype || msg2_dest !== e.dest || msg2_addr !== e.addr ||
                    (e.chk_data && msg2_data !== e.data)) begin
                    $display("FAIL msg2_%h: got type=%h dest=%0d addr=%h data=%h, required type=%h dest=%0d addr=%h data=%h",
                             e.mtype, msg2_type, msg2_dest, msg2_addr, msg2_data,
                             e.mtype, e.dest, e.addr, e.data);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic push(input logic [7:0] t, input logic [5:0] d, input logic [29:0] a,
                        input logic [63:0] dt, input bit c);
        exp_t e;
        e.mtype = t;
        e.dest = d;
        e.addr = a;
        e.data = dt;
        e.chk_data = c;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] t, input logic [5:0] s, input logic [29:0] a);
        msg1_valid = 1'b1;
        msg1_type = t;
        msg1_source = s;
        msg1_addr = a;
        @(posedge clk);
        #1;
        msg1_valid = 1'b0;
    endtask

    task automatic respond(input logic [7:0] t, input logic [63:0] d);
        msg3_valid = 1'b1;
        msg3_type = t;
        msg3_data = d;
        @(posedge clk);
        #1;
        msg3_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain_%s: %0d messages outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        #3;
        n_total++;
        if ({msg1_ready, msg2_valid, msg3_ready, busy} !== 4'b0 || replay_cnt !== 8'd0) begin
            $display("FAIL reset_outputs: got rdy1=%b v2=%b rdy3=%b busy=%b cnt=%0d, required all 0",
                     msg1_ready, msg2_valid, msg3_ready, busy, replay_cnt);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (msg1_ready !== 1'b0) begin
            $display("FAIL reset_release_ready: got %b, required 0 before first clock", msg1_ready);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (msg1_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_first_clock: got rdy1=%b busy=%b, required 1/0", msg1_ready, busy);
        end else n_pass++;
    endtask

    task automatic test_cold_miss;
        push(8'h13, 6'd0, 30'h403, 64'h0, 1'b0);
        load(8'h1f, 6'd5, 30'h403);
        drain("cold_memread");
        push(8'h1d, 6'd5, 30'h403, 64'hABCD, 1'b1);
        respond(8'h20, 64'hABCD);
        drain("cold_ack");
        n_total++;
        if (replay_cnt !== 8'd1 || dut.lstate_q[3] !== 2'd2 || dut.owner_q[3] !== 6'd5) begin
            $display("FAIL cold_state: got cnt=%0d state=%0d owner=%0d, required 1/2/5",
                     replay_cnt, dut.lstate_q[3], dut.owner_q[3]);
        end else n_pass++;
    endtask

    task automatic test_owner_forward;
        push(8'h10, 6'd5, 30'h403, 64'h0, 1'b0);
        load(8'h1f, 6'd9, 30'h403);
        drain("fwd_down");
        push(8'h1d, 6'd9, 30'h403, 64'h55, 1'b1);
        respond(8'h21, 64'h55);
        drain("fwd_ack");
        n_total++;
        if (dut.lstate_q[3] !== 2'd1 || dut.share_q[3] !== 64'h220 || dut.vd_q[3] !== 2'd3 ||
            replay_cnt !== 8'd2) begin
            $display("FAIL fwd_state: got state=%0d share=%h vd=%0d cnt=%0d, required 1/220/3/2",
                     dut.lstate_q[3], dut.share_q[3], dut.vd_q[3], replay_cnt);
        end else n_pass++;
    endtask

    task automatic test_s_hit_join;
        push(8'h1d, 6'd7, 30'h403, 64'h55, 1'b1);
        load(8'h1f, 6'd7, 30'h403);
        n_total++;
        if (msg2_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL join_lookup_cycle: got v2=%b busy=%b, required 0/1", msg2_valid, busy);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (msg2_valid !== 1'b1) begin
            $display("FAIL join_valid_n2: got %b, required 1", msg2_valid);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (msg1_ready !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
            $display("FAIL join_idle_n3: got rdy1=%b busy=%b pending=%0d, required 1/0/0",
                     msg1_ready, busy, exp_q.size());
        end else n_pass++;
        n_total++;
        if (dut.share_q[3] !== 64'h2A0) begin
            $display("FAIL join_share: got %h, required 2a0", dut.share_q[3]);
        end else n_pass++;
    endtask

    task automatic test_backpressure;
        msg2_ready = 1'b0;
        push(8'h1d, 6'd7, 30'h403, 64'h55, 1'b1);
        load(8'h1f, 6'd7, 30'h403);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (msg2_valid !== 1'b1 || msg2_type !== 8'h1d || msg2_dest !== 6'd7 ||
                msg2_addr !== 30'h403 || msg2_data !== 64'h55 || msg1_ready !== 1'b0) begin
                $display("FAIL bp_hold_%0d: got v=%b type=%h dest=%0d addr=%h data=%h rdy1=%b, required 1/1d/7/403/55/0",
                         i, msg2_valid, msg2_type, msg2_dest, msg2_addr, msg2_data, msg1_ready);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        msg2_ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (msg2_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            $display("FAIL bp_release: got v2=%b busy=%b pending=%0d, required 0/0/0",
                     msg2_valid, busy, exp_q.size());
        end else n_pass++;
    endtask

    task automatic test_drop;
        load(8'h05, 6'd3, 30'h403);
        n_total++;
        if (busy !== 1'b0 || msg1_ready !== 1'b1) begin
            $display("FAIL drop_other_type: got busy=%b rdy1=%b, required 0/1", busy, msg1_ready);
        end else n_pass++;
    endtask

    task automatic test_dirty_evict;
        push(8'h12, 6'd0, 30'h403, 64'h0, 1'b0);
        load(8'h1f, 6'd2, 30'h413);
        drain("evict_sharers");
        respond(8'h30, 64'hDEAD);
        n_total++;
        if (busy !== 1'b1 || msg3_ready !== 1'b1) begin
            $display("FAIL wait_ignore: got busy=%b rdy3=%b, required 1/1", busy, msg3_ready);
        end else n_pass++;
        push(8'h14, 6'd0, 30'h403, 64'h55, 1'b1);
        push(8'h13, 6'd0, 30'h413, 64'h0, 1'b0);
        respond(8'h22, 64'h0);
        drain("wb_memread");
        push(8'h1d, 6'd2, 30'h413, 64'h1234, 1'b1);
        respond(8'h20, 64'h1234);
        drain("dirty_ack");
        n_total++;
        if (replay_cnt !== 8'd5 || dut.vd_q[3] !== 2'd2 || dut.owner_q[3] !== 6'd2) begin
            $display("FAIL dirty_state: got cnt=%0d vd=%0d owner=%0d, required 5/2/2",
                     replay_cnt, dut.vd_q[3], dut.owner_q[3]);
        end else n_pass++;
    endtask

    task automatic test_evict_owner;
        push(8'h11, 6'd2, 30'h413, 64'h0, 1'b0);
        load(8'h1f, 6'd4, 30'h423);
        drain("evict_owner");
        push(8'h14, 6'd0, 30'h413, 64'h77, 1'b1);
        push(8'h13, 6'd0, 30'h423, 64'h0, 1'b0);
        respond(8'h22, 64'h77);
        drain("owner_wb");
        push(8'h1d, 6'd4, 30'h423, 64'h99, 1'b1);
        respond(8'h20, 64'h99);
        drain("owner_ack");
        n_total++;
        if (replay_cnt !== 8'd8) begin
            $display("FAIL owner_replays: got %0d, required 8", replay_cnt);
        end else n_pass++;
    endtask

    task automatic test_reset_wait;
        push(8'h13, 6'd0, 30'h505, 64'h0, 1'b0);
        load(8'h1f, 6'd1, 30'h505);
        drain("rw_memread");
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({msg1_ready, msg2_valid, msg3_ready, busy} !== 4'b0 || replay_cnt !== 8'd0 ||
            msg2_type !== 8'd0 || msg2_dest !== 6'd0 || msg2_addr !== 30'd0 || msg2_data !== 64'd0) begin
            $display("FAIL rw_outputs: got rdy1=%b v2=%b rdy3=%b busy=%b cnt=%0d type=%h, required all 0",
                     msg1_ready, msg2_valid, msg3_ready, busy, replay_cnt, msg2_type);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (msg1_ready !== 1'b1 || busy !== 1'b0 || msg3_ready !== 1'b0) begin
            $display("FAIL rw_release: got rdy1=%b busy=%b rdy3=%b, required 1/0/0",
                     msg1_ready, busy, msg3_ready);
        end else n_pass++;
        // Array was cleared, so the old line misses again
        push(8'h13, 6'd0, 30'h403, 64'h0, 1'b0);
        load(8'h1f, 6'd5, 30'h403);
        drain("rw_cold");
        push(8'h1d, 6'd5, 30'h403, 64'h1, 1'b1);
        respond(8'h20, 64'h1);
        drain("rw_ack");
        n_total++;
        if (replay_cnt !== 8'd1) begin
            $display("FAIL rw_replays: got %0d, required 1", replay_cnt);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_owner_forward();
        test_s_hit_join();
        test_backpressure();
        test_drop();
        test_dirty_evict();
        test_evict_owner();
        test_reset_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l2_load_dir.md
# l2_load_dir

Multi-set, parametrised L2 load-request directory engine for the PMESH L2. It accepts load requests (type 0x1f) on the msg1 channel and looks them up in a direct-mapped array of line and directory state. It then either replies with a data ack or issues coherence and memory requests on msg2, waits for responses on msg3, and replays the pending request until it completes. Compared with the single-line, single-shot LOAD_REQ model, this block adds:

- `NUM_SETS` lines
- backpressure on msg2
- a response-wait state
- automatic replay

## Interface
- `IDX_W`, default 4: set index width; `NUM_SETS = 2**IDX_W`.
- `TAG_W`, default 26: tag width.
- `DATA_W`, default 64: line data width.
- `NUM_CORES`, default 64: share-list width. `SRC_W = $clog2(NUM_CORES)`.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: reset, asynchronous and active-low.
- `msg1_valid` / `msg1_ready`: input 1 / output 1; request handshake.
- `msg1_type` input 8, `msg1_source` input `SRC_W`, `msg1_addr` input `TAG_W+IDX_W`. Index is `addr[IDX_W-1:0]`; tag is the upper bits.
- `msg2_valid` output 1, `msg2_ready` input 1.
- `msg2_type` output 8, `msg2_dest` output `SRC_W`, `msg2_addr` output `TAG_W+IDX_W`, `msg2_data` output `DATA_W`.
- `msg3_valid` input 1, `msg3_ready` output 1.
- `msg3_type` input 8, `msg3_data` input `DATA_W`.
- `busy` output 1: FSM not in IDLE.
- `replay_cnt` output 8: saturating count of replays since reset.

## Operation
- **Per-set storage:**
  - `tag`.
  - `vd`: 0 = invalid, 2 = valid clean, 3 = valid dirty.
  - `state`: 0 = I, 1 = S, 2 = M.
  - `owner`, `share_list[NUM_CORES]`, `data`.
- **FSM states:** IDLE, LOOKUP, SEND, WAIT, REPLAY.
- **IDLE:**
  - `msg1_ready = 1`.
  - On handshake with type 0x1f, latch type, source, addr → LOOKUP.
  - Other types are consumed and dropped; FSM stays in IDLE.
- **LOOKUP** (one cycle): `hit = (tag == req_tag) & vd[1]`. Decision, first match wins:
  - hit, I: state←M, owner←src; send 0x1d to src with data; next = IDLE.
  - hit, S: `share_list |= 1<<src`; send 0x1d; next = IDLE.
  - hit, M, owner==src: send 0x1d; next = IDLE.
  - hit, M, owner≠src: send 0x10 (forward-downgrade) to owner; next = WAIT.
  - miss, vd==0: send 0x13 (mem read) to dest 0 with req addr; next = WAIT.
  - miss, M: send 0x11 (evict-owner) to owner; next = WAIT.
  - miss, S: send 0x12 (evict-sharers) to dest 0; next = WAIT.
  - miss, I, vd==3: send 0x14 (writeback) with line tag/index and data, vd←0; next = REPLAY.
  - miss, I, vd==2: vd←0, no message; → REPLAY directly.
- **SEND:**
  - `msg2_*` registered and held stable while `msg2_valid & !msg2_ready`.
  - On handshake, go to the stored next state.
- **WAIT:**
  - `msg3_ready = 1`; `msg3_ready = 0` in every other state.
  - 0x20 mem-data: tag←req tag, data←msg3_data, vd←2, state←I, share_list←0 → REPLAY.
  - 0x21 fwd-ack: state←S, share_list←1<<old owner, data←msg3_data, vd←3 → REPLAY.
  - 0x22 inv-ack: state←I, share_list←0. If the pending message was 0x11, also data←msg3_data, vd←3 → REPLAY.
  - Any other type: consumed and ignored; FSM stays in WAIT.
- **REPLAY:**
  - `replay_cnt` increments, saturating at 255.
  - Next cycle is LOOKUP with the same latched request.
- Only one request is in flight; `msg1_ready = 0` outside IDLE.

## Timing
- **Reset** (asynchronous, `rst` low):
  - All outputs 0.
  - FSM to IDLE.
  - Every set: vd=0, state=I, owner=0, share_list=0, tag=0, data=0.
- `msg1_ready` rises on the first clock after `rst` deasserts.
- **Hit latency:** accept at cycle N, LOOKUP at N+1, `msg2_valid` at N+2. If `msg2_ready` is high, IDLE at N+3 and `msg1_ready` high at N+3.
- **Miss chain latency:** each REPLAY adds 2 cycles (REPLAY, LOOKUP) before the next `msg2_valid`.
- **Reset mid-operation:**
  - A pending request is discarded.
  - `msg2_valid` drops asynchronously.
  - No msg3 response is awaited after reset.
- **Array updates:** occur on the LOOKUP→SEND or WAIT→REPLAY clock edge. Same-set updates are therefore visible to the next LOOKUP.
- **Shifts:** `1<<src` is computed at `NUM_CORES` width; src < `NUM_CORES` is guaranteed by the sender.
- `msg3_valid` outside WAIT is not consumed.

## Test plan
- **Cold miss:** after reset, load src=5, addr=0x40_3.
  - Expect: 0x13 to dest 0, addr 0x40_3.
  - Respond 0x20 with data 0xABCD.
  - Expect: replay, then 0x1d to dest 5 with data 0xABCD; set 3 state=M, owner=5; `replay_cnt`=1.
- **S-hit join:** set 3 S, share_list=0x1.
  - Load src=7 with a matching tag.
  - Expect: 0x1d at cycle N+2; share_list=0x81.
- **Owner forward:** set 3 M, owner=5; load src=9.
  - Expect: 0x10 to dest 5.
  - Respond 0x21 with data 0x55.
  - Expect: replay, then 0x1d to 9; state S; share_list=(1<<5)|(1<<9); vd=3.
- **Dirty eviction chain:** set 3 I, vd=3, other tag; load to the same index.
  - Expect, in order: 0x14 carrying old data, replay, 0x13, then 0x20, replay, 0x1d; `replay_cnt`=2.
- **Backpressure:** hold `msg2_ready=0` for 5 cycles during a 0x1d response.
  - Expect: `msg2_*` stable for all 5 cycles, `msg1_ready=0`, and a single handshake when ready rises.
- **Reset in WAIT:** pull `rst` low while waiting for 0x20.
  - Expect: all outputs 0 immediately; after release, `msg1_ready=1` and `busy=0`.
